// File: rtl/instr_mem_fetch.sv
// Instruction memory with a synchronous read, a configurable read pipeline and a
// request/response fetch handshake. A program-load write port fills the array.
module instr_mem_fetch #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DEPTH        = 256,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_index,
    input  logic [DATA_WIDTH-1:0]    load_data,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_pc,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_instr,
    output logic [ADDR_WIDTH-1:0]    rsp_pc,
    output logic [1:0]               rsp_fault
);

    localparam int IDX_W = $clog2(DEPTH);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; a producer holds its payload stable while valid is high and ready is low.

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  stall;
    logic                  accept;
    logic [IDX_W-1:0]      req_index;
    logic [1:0]            req_fault;

    logic [READ_LATENCY-1:0] stg_valid;
    logic [ADDR_WIDTH-1:0]   stg_pc    [READ_LATENCY];
    logic [1:0]              stg_fault [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   stg_data  [READ_LATENCY];

    assign stall     = stg_valid[READ_LATENCY-1] && !rsp_ready;
    assign req_ready = !stall && !load_en && !reset;
    assign accept    = req_valid && req_ready;

    assign req_index    = req_pc[IDX_W+1:2];
    assign req_fault[0] = (req_pc[1:0] != 2'b00);
    assign req_fault[1] = ((req_pc >> 2) >= ADDR_WIDTH'(DEPTH));

    // The array has no reset so a program loaded before or during reset survives it.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_index] <= load_data;
        end
    end

    // Stage 0 holds the synchronous array read; later stages only delay it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                stg_pc[i]    <= '0;
                stg_fault[i] <= '0;
                stg_data[i]  <= '0;
            end
        end else if (!stall) begin
            stg_valid[0] <= accept;
            if (accept) begin
                stg_pc[0]    <= req_pc;
                stg_fault[0] <= req_fault;
                stg_data[0]  <= (req_fault != 2'b00) ? NOP_WORD : mem[req_index];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_pc[i]    <= stg_pc[i-1];
                stg_fault[i] <= stg_fault[i-1];
                stg_data[i]  <= stg_data[i-1];
            end
        end
    end

    assign rsp_valid = stg_valid[READ_LATENCY-1];
    assign rsp_pc    = stg_pc[READ_LATENCY-1];
    assign rsp_fault = stg_fault[READ_LATENCY-1];
    assign rsp_instr = stg_data[READ_LATENCY-1];

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch: four instances (read latency 1..4) share one stimulus
// stream and each is scored against an array/queue model of the fetch rules.
module tb_instr_mem_fetch;

    localparam int          DEPTH = 256;
    localparam int          NINST = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              load_en;
    logic [7:0]        load_index;
    logic [31:0]       load_data;
    logic              req_valid;
    logic [31:0]       req_pc;
    logic [NINST-1:0]  rsp_ready_v;
    logic [NINST-1:0]  req_ready_v;
    logic [NINST-1:0]  rsp_valid_v;
    logic [NINST-1:0][31:0] rsp_instr_v;
    logic [NINST-1:0][31:0] rsp_pc_v;
    logic [NINST-1:0][1:0]  rsp_fault_v;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        instr_mem_fetch #(
            .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH),
            .READ_LATENCY(g + 1), .NOP_WORD(NOP)
        ) dut (
            .clk(clk), .reset(reset),
            .load_en(load_en), .load_index(load_index), .load_data(load_data),
            .req_valid(req_valid), .req_ready(req_ready_v[g]), .req_pc(req_pc),
            .rsp_valid(rsp_valid_v[g]), .rsp_ready(rsp_ready_v[g]),
            .rsp_instr(rsp_instr_v[g]), .rsp_pc(rsp_pc_v[g]), .rsp_fault(rsp_fault_v[g])
        );
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: word array plus one expected-response queue per instance.
    logic [31:0] model_mem [DEPTH];
    logic [65:0] exp_q [NINST][$];
    int          pop_cnt [NINST];

    function automatic logic [65:0] expect_rsp(input logic [31:0] pc);
        logic [1:0]  f;
        logic [31:0] d;
        f[0] = (pc % 4) != 0;
        f[1] = (pc / 4) >= DEPTH;
        d = (f != 2'b00) ? NOP : model_mem[int'(pc / 4)];
        return {f, pc, d};
    endfunction

    always @(negedge clk) begin
        for (int j = 0; j < NINST; j++) begin
            if (reset) begin
                exp_q[j].delete();
            end else begin
                n_cmp++;
                if (req_ready_v[j] !== (!(rsp_valid_v[j] && !rsp_ready_v[j]) && !load_en)) begin
                    n_fail++;
                    $display("FAIL req_ready[%0d]: got %b want %b", j, req_ready_v[j],
                             !(rsp_valid_v[j] && !rsp_ready_v[j]) && !load_en);
                end
                if (rsp_valid_v[j] === 1'b1) begin
                    n_cmp++;
                    if (exp_q[j].size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_rsp[%0d]: got pc %h want no response", j, rsp_pc_v[j]);
                    end else begin
                        if ({rsp_fault_v[j], rsp_pc_v[j], rsp_instr_v[j]} !== exp_q[j][0]) begin
                            n_fail++;
                            $display("FAIL rsp[%0d]: got fault/pc/instr %h want %h", j,
                                     {rsp_fault_v[j], rsp_pc_v[j], rsp_instr_v[j]}, exp_q[j][0]);
                        end
                        if (rsp_ready_v[j]) begin
                            void'(exp_q[j].pop_front());
                            pop_cnt[j]++;
                        end
                    end
                end
                if (req_valid && req_ready_v[j] === 1'b1) begin
                    exp_q[j].push_back(expect_rsp(req_pc));
                end
            end
        end
        if (load_en) model_mem[load_index] = load_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid   = 1'b0;
        load_en     = 1'b0;
        rsp_ready_v = '1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; load_en = 1'b0; load_index = '0; load_data = '0;
        req_valid = 1'b0; req_pc = '0; rsp_ready_v = '1;
        tick();
        // The whole program image is written while reset is held.
        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1'b1; load_index = 8'(i); load_data = $urandom;
            req_valid = (i == 0); req_pc = 32'h0;
            if (i == 0) begin
                @(negedge clk);
                n_cmp++;
                if (req_ready_v !== 4'h0) begin
                    n_fail++;
                    $display("FAIL ready_in_reset: got %b want 0000", req_ready_v);
                end
            end
            tick();
        end
        load_en = 1'b0; req_valid = 1'b0; reset = 1'b0;
        @(negedge clk);
        for (int j = 0; j < NINST; j++) begin
            n_cmp++;
            if ({rsp_valid_v[j], rsp_instr_v[j], rsp_pc_v[j], rsp_fault_v[j], req_ready_v[j]} !== {1'b0, 32'h0, 32'h0, 2'b00, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got valid %b instr %h pc %h fault %b ready %b want 0 0 0 00 1",
                         j, rsp_valid_v[j], rsp_instr_v[j], rsp_pc_v[j], rsp_fault_v[j], req_ready_v[j]);
            end
        end
        tick();
    endtask

    task automatic test_stream();
        int base [NINST];
        for (int i = 0; i < 18; i++) begin
            load_en = 1'b1; load_index = 8'(i); load_data = 32'h1000_0000 + 32'(i);
            tick();
        end
        load_en = 1'b0;
        for (int j = 0; j < NINST; j++) base[j] = pop_cnt[j];
        for (int i = 0; i < 18; i++) begin
            req_valid = 1'b1; req_pc = 32'(4 * i);
            @(negedge clk);
            n_cmp++;
            if (req_ready_v !== 4'hF) begin
                n_fail++;
                $display("FAIL stream_ready[%0d]: got %b want 1111", i, req_ready_v);
            end
            tick();
        end
        drain();
        for (int j = 0; j < NINST; j++) begin
            n_cmp++;
            if (pop_cnt[j] - base[j] != 18) begin
                n_fail++;
                $display("FAIL stream_count[%0d]: got %0d want 18", j, pop_cnt[j] - base[j]);
            end
        end
    endtask

    task automatic test_faults();
        logic [31:0] pcs [6];
        logic [1:0]  flt [6];
        logic [31:0] want;
        pcs = '{32'd6, 32'd1024, 32'd1026, 32'd1020, 32'hFFFF_FFFC, 32'd3};
        flt = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01};
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_pc = pcs[i];
            tick();
            req_valid = 1'b0;
            want = (flt[i] != 2'b00) ? NOP : model_mem[255];
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid_v[0], rsp_fault_v[0], rsp_instr_v[0]} !== {1'b1, flt[i], want}) begin
                n_fail++;
                $display("FAIL fault pc=%h: got valid %b fault %b instr %h want 1 %b %h",
                         pcs[i], rsp_valid_v[0], rsp_fault_v[0], rsp_instr_v[0], flt[i], want);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_backpressure();
        int i = 0;
        int c = 0;
        int base = pop_cnt[1];
        while (i < 13 && c < 60) begin
            req_valid = 1'b1; req_pc = 32'(4 * i);
            rsp_ready_v = (c >= 3 && c <= 5) ? 4'b1101 : 4'b1111;
            @(negedge clk);
            if (c >= 3 && c <= 5) begin
                n_cmp++;
                if ({req_ready_v[1], rsp_valid_v[1]} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL stall_cycle%0d: got ready %b valid %b want 0 1", c, req_ready_v[1], rsp_valid_v[1]);
                end
            end
            if (req_ready_v[1]) i++;
            tick();
            c++;
        end
        n_cmp++;
        if (i != 13) begin
            n_fail++;
            $display("FAIL bp_accept_timeout: got %0d want 13", i);
        end
        drain();
        n_cmp++;
        if (pop_cnt[1] - base != 13) begin
            n_fail++;
            $display("FAIL bp_count: got %0d want 13", pop_cnt[1] - base);
        end
    endtask

    task automatic test_collision();
        load_en = 1'b1; load_index = 8'd3; load_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_pc = 32'd12;
        @(negedge clk);
        n_cmp++;
        if (req_ready_v !== 4'h0) begin
            n_fail++;
            $display("FAIL collision_ready: got %b want 0000", req_ready_v);
        end
        tick();
        load_en = 1'b0;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid_v[0], rsp_instr_v[0]} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL collision_data: got %b %h want 1 deadbeef", rsp_valid_v[0], rsp_instr_v[0]);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        req_valid = 1'b1; req_pc = 32'd20;
        tick();
        req_pc = 32'd24;
        tick();
        req_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid_v !== 4'h0) begin
                n_fail++;
                $display("FAIL dropped_after_reset[%0d]: got %b want 0000", n, rsp_valid_v);
            end
            tick();
        end
        req_valid = 1'b1; req_pc = 32'd20;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid_v[2], rsp_instr_v[2]} !== {1'b1, model_mem[5]}) begin
            n_fail++;
            $display("FAIL post_reset_fetch: got %b %h want 1 %h", rsp_valid_v[2], rsp_instr_v[2], model_mem[5]);
        end
        drain();
    endtask

    task automatic test_latency();
        int first [NINST];
        for (int r = 0; r < 3; r++) begin
            req_valid = 1'b1; req_pc = 32'(4 * $urandom_range(0, DEPTH - 1));
            tick();
            req_valid = 1'b0;
            for (int j = 0; j < NINST; j++) first[j] = -1;
            for (int n = 0; n < 6; n++) begin
                @(negedge clk);
                for (int j = 0; j < NINST; j++)
                    if (rsp_valid_v[j] === 1'b1 && first[j] < 0) first[j] = n;
                tick();
            end
            for (int j = 0; j < NINST; j++) begin
                n_cmp++;
                if (first[j] != j) begin
                    n_fail++;
                    $display("FAIL latency_rl%0d: got %0d edges want %0d", j + 1, first[j], j);
                end
            end
            drain();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            load_en    = ($urandom_range(0, 7) == 0);
            load_index = 8'($urandom_range(0, DEPTH - 1));
            load_data  = $urandom;
            req_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       req_pc = $urandom;
                1:       req_pc = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
                default: req_pc = 32'(4 * $urandom_range(0, DEPTH - 1));
            endcase
            rsp_ready_v = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            tick();
        end
        drain();
    endtask

    initial begin
        for (int j = 0; j < NINST; j++) pop_cnt[j] = 0;
        test_reset();
        test_stream();
        test_faults();
        test_backpressure();
        test_collision();
        test_reset_midflight();
        test_latency();
        test_random();
        for (int j = 0; j < NINST; j++) begin
            n_cmp++;
            if (exp_q[j].size() != 0) begin
                n_fail++;
                $display("FAIL leftover[%0d]: got %0d pending want 0", j, exp_q[j].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
